stream_job_scheduler: RTL
=========================

Name: stream_job_scheduler

Overview:
- Shares one AXI4-Stream source block among NUM_REQ requesters.
- Each requester submits a job (byte count, destination). The scheduler arbitrates round-robin and programs the source over its AXI4-Lite master port:
  - NUM_BYTES @0x10, then DEST @0x14, then CONTROL=1 @0x00.
- It then polls STATUS @0x04 until bit0 (busy) clears, and reports completion to the owning requester.
- It sits between the software/job-generation logic and the stream source's register slave.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_WIDTH, 5, AXI4-Lite address width
- DATA_WIDTH, 32, AXI4-Lite data width (fixed at 32)
- STREAM_DATA_BYTES, 4, bytes per stream beat; minimum legal job size
- POLL_GAP, 4, idle cycles before each STATUS read (must be >=1)
- MAX_POLLS, 1024, STATUS reads before timeout; 0 disables timeout

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester job request; held until req_ready
- req_num_bytes  in  NUM_REQ*32  per-requester byte count, packed, requester i at [32i+31:32i]
- req_dest  in  NUM_REQ*2  per-requester TDEST, packed
- req_ready  out  NUM_REQ  one-hot single-cycle accept pulse
- done_valid  out  1  single-cycle job completion pulse
- done_id  out  clog2(NUM_REQ)  requester index of completed job
- done_err  out  1  job failed (qualified by done_valid)
- busy  out  1  job in flight
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY  AXI4-Lite write channels; widths per ADDR_WIDTH/DATA_WIDTH
- M_AXI_ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY  AXI4-Lite read channels

Behaviour:
- Reset (async, immediate):
  - State=IDLE.
  - All VALID/READY outputs 0, done_* 0, busy 0.
  - RR pointer = NUM_REQ-1, so requester 0 has first priority.
  - Addresses/data 0.
  - Reset mid-transaction abandons it; the slave is re-initialised by the same reset domain.
- AWPROT/ARPROT=3'b000; WSTRB=all ones.
- States: IDLE, CHECK, WR, WR_RESP, GAP, RD, RD_RESP, DONE.
- IDLE:
  - If any req_valid: grant the first requester after the RR pointer (wrapping).
  - Pulse req_ready[g] for one cycle, latch num_bytes/dest/id, update pointer=g, go to CHECK.
  - busy=1 from the cycle after the grant until DONE exits.
- CHECK: if num_bytes < STREAM_DATA_BYTES, err=1 and go to DONE with no AXI traffic; else go to WR with step=NUM_BYTES.
- WR:
  - Assert AWVALID and WVALID together; drop each independently on its own handshake.
  - Leave WR when both have completed (the slave accepts AW before W; both orders must be supported).
  - Go to WR_RESP.
- WR_RESP:
  - BREADY=1; on BVALID, if BRESP!=0 then err=1 and go to DONE.
  - Else advance step NUM_BYTES -> DEST (WDATA={30'b0,dest}) -> CTRL (WDATA=1) -> go to GAP.
- GAP: wait POLL_GAP cycles (counter), then go to RD.
- RD: ARVALID, ARADDR=0x04 until ARREADY; go to RD_RESP.
- RD_RESP:
  - RREADY=1; on RVALID, increment poll count.
  - If RRESP!=0: err.
  - Else if RDATA[0]=0: done OK.
  - Else if MAX_POLLS!=0 and count==MAX_POLLS: err (timeout).
  - Else go to GAP.
- DONE: done_valid=1 for one cycle with done_id and done_err; go to IDLE. A new grant is possible the next cycle.
- One job in flight at a time. req_valid from the granted requester after its req_ready is treated as a new job.
- Requests arriving during a job wait; later ones never starve (RR fairness).
- The CTRL write of WDATA=1 is the sole start trigger. Each job is written fresh; nothing is reused.

Test Plan:
- Single job (req 0, num_bytes=16, dest=2); slave answers immediately:
  - Writes occur in order 0x10=16, 0x14=2, 0x00=1.
  - The source emits 4 beats with TDATA 0..3, TLAST on the 4th beat, TDEST=2.
  - After busy clears: done_valid, done_id=0, done_err=0.
- All 4 requesters assert simultaneously, held:
  - Grant order is 0,1,2,3.
  - If req 0 re-asserts, it is served after 3, and done_id sequences match.
- num_bytes=2 -> no AXI transactions; done_err=1 two cycles after grant.
- Stub slave with TREADY held 0 and MAX_POLLS=3 -> exactly 3 STATUS reads, then done_err=1.
- Stub slave returning BRESP=2 on the DEST write -> CTRL is never written; done_err=1.
- Assert reset during WR with AWVALID high -> AWVALID/WVALID drop the same cycle.
  - After release: IDLE, req_ready for req 0 first.

Source files
------------

// File: rtl/stream_job_scheduler_if.sv
// stream_job_scheduler_if: AXI4-Lite master/slave bundle between the scheduler and the stream source registers
interface stream_job_scheduler_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;
  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/stream_job_scheduler.sv
// stream_job_scheduler: round-robin job arbiter that programs and polls a shared stream source over AXI4-Lite
module stream_job_scheduler #(
  parameter int NUM_REQ           = 4,
  parameter int ADDR_WIDTH        = 5,
  parameter int DATA_WIDTH        = 32,
  parameter int STREAM_DATA_BYTES = 4,
  parameter int POLL_GAP          = 4,
  parameter int MAX_POLLS         = 1024
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*32-1:0]      req_num_bytes,
  input  logic [NUM_REQ*2-1:0]       req_dest,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       done_valid,
  output logic [$clog2(NUM_REQ)-1:0] done_id,
  output logic                       done_err,
  output logic                       busy,
  stream_job_scheduler_if.master     m_axi
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int GW = POLL_GAP > 1 ? $clog2(POLL_GAP) : 1;
  localparam logic [ADDR_WIDTH-1:0] A_CTRL = ADDR_WIDTH'(8'h00);
  localparam logic [ADDR_WIDTH-1:0] A_STAT = ADDR_WIDTH'(8'h04);
  localparam logic [ADDR_WIDTH-1:0] A_NB   = ADDR_WIDTH'(8'h10);
  localparam logic [ADDR_WIDTH-1:0] A_DEST = ADDR_WIDTH'(8'h14);
  typedef enum logic [2:0] {IDLE, CHECK, WR, WR_RESP, GAP, RD, RD_RESP, DONE} state_t;
  state_t          state;
  logic [IW-1:0]   ptr, gnt, j;
  logic [31:0]     num_bytes, polls;
  logic [1:0]      dest, step;
  logic [GW-1:0]   gap;
  assign m_axi.awprot = '0;
  assign m_axi.arprot = '0;
  assign m_axi.wstrb  = '1;
  // scan downward so the nearest requester after ptr wins
  always_comb begin
    gnt = '0;
    j = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      j = IW'((int'(ptr) + i) % NUM_REQ);
      if (req_valid[j]) gnt = j;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      ptr           <= IW'(NUM_REQ-1);
      req_ready     <= '0;
      done_valid    <= 1'b0;
      done_id       <= '0;
      done_err      <= 1'b0;
      busy          <= 1'b0;
      num_bytes     <= '0;
      dest          <= '0;
      step          <= '0;
      gap           <= '0;
      polls         <= '0;
      m_axi.awaddr  <= '0;
      m_axi.awvalid <= 1'b0;
      m_axi.wdata   <= '0;
      m_axi.wvalid  <= 1'b0;
      m_axi.bready  <= 1'b0;
      m_axi.araddr  <= '0;
      m_axi.arvalid <= 1'b0;
      m_axi.rready  <= 1'b0;
    end else begin
      req_ready  <= '0;
      done_valid <= 1'b0;
      case (state)
        IDLE: if (|req_valid) begin
          req_ready[gnt] <= 1'b1;
          ptr            <= gnt;
          done_id        <= gnt;
          num_bytes      <= req_num_bytes[32*gnt +: 32];
          dest           <= req_dest[2*gnt +: 2];
          busy           <= 1'b1;
          state          <= CHECK;
        end
        CHECK: begin
          polls <= '0;
          step  <= '0;
          if (num_bytes < 32'(STREAM_DATA_BYTES)) begin
            done_valid <= 1'b1;
            done_err   <= 1'b1;
            state      <= DONE;
          end else begin
            m_axi.awaddr  <= A_NB;
            m_axi.wdata   <= DATA_WIDTH'(num_bytes);
            m_axi.awvalid <= 1'b1;
            m_axi.wvalid  <= 1'b1;
            state         <= WR;
          end
        end
        // AW and W complete independently, in either order
        WR: begin
          if (m_axi.awready) m_axi.awvalid <= 1'b0;
          if (m_axi.wready) m_axi.wvalid <= 1'b0;
          if ((!m_axi.awvalid || m_axi.awready) && (!m_axi.wvalid || m_axi.wready)) begin
            m_axi.bready <= 1'b1;
            state        <= WR_RESP;
          end
        end
        WR_RESP: if (m_axi.bvalid) begin
          m_axi.bready <= 1'b0;
          if (m_axi.bresp != 2'b00) begin
            done_valid <= 1'b1;
            done_err   <= 1'b1;
            state      <= DONE;
          end else if (step == 2'd2) begin
            gap   <= '0;
            state <= GAP;
          end else begin
            step          <= step + 2'd1;
            m_axi.awaddr  <= step == 2'd0 ? A_DEST : A_CTRL;
            m_axi.wdata   <= step == 2'd0 ? DATA_WIDTH'(dest) : DATA_WIDTH'(1);
            m_axi.awvalid <= 1'b1;
            m_axi.wvalid  <= 1'b1;
            state         <= WR;
          end
        end
        GAP: if (gap == GW'(POLL_GAP-1)) begin
          m_axi.araddr  <= A_STAT;
          m_axi.arvalid <= 1'b1;
          state         <= RD;
        end else gap <= gap + 1'b1;
        RD: if (m_axi.arready) begin
          m_axi.arvalid <= 1'b0;
          m_axi.rready  <= 1'b1;
          state         <= RD_RESP;
        end
        // error response, idle source, or exhausted poll budget all end the job
        RD_RESP: if (m_axi.rvalid) begin
          m_axi.rready <= 1'b0;
          polls        <= polls + 32'd1;
          if (m_axi.rresp != 2'b00 || !m_axi.rdata[0] ||
              (MAX_POLLS != 0 && polls + 32'd1 == 32'(MAX_POLLS))) begin
            done_valid <= 1'b1;
            done_err   <= m_axi.rresp != 2'b00 || m_axi.rdata[0];
            state      <= DONE;
          end else begin
            gap   <= '0;
            state <= GAP;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
